// File: rtl/clock_display_scan.sv
// MM.SS clock display driver: sequential double-dabble BCD conversion plus a 4-digit 7-segment scanner.
// Define LEAD_ZERO_BLANK_EN to blank the minutes-tens digit when it is zero.
module clock_display_scan #(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] seconds_in,
    input  logic [5:0] minutes_in,
    output logic [3:0] digit_en,
    output logic [6:0] seg_out,
    output logic       dp_out,
    output logic       conv_busy
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [5:0]    last_sec;
    logic [5:0]    last_min;
    logic [13:0]   sr_sec;
    logic [13:0]   sr_min;
    logic [2:0]    shift_cnt;
    logic [3:0]    sec_units;
    logic [3:0]    sec_tens;
    logic [3:0]    min_units;
    logic [3:0]    min_tens;
    logic          start;
    logic [PW-1:0] pre;
    logic [1:0]    idx;
    logic [1:0]    idx_next;
    logic [3:0]    cur_digit;
    logic [6:0]    seg_on;

    // One double-dabble step: BCD nibbles sit above the 6 binary bits.
    function automatic logic [13:0] dd_step(input logic [13:0] sr);
        logic [13:0] a;
        a = sr;
        if (a[13:10] >= 4'd5) a[13:10] = a[13:10] + 4'd3;
        if (a[9:6] >= 4'd5)   a[9:6]   = a[9:6] + 4'd3;
        return {a[12:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign start = (state == IDLE) && ({minutes_in, seconds_in} != {last_min, last_sec});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (shift_cnt == 3'd5) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        conv_busy = (state == SHIFT) || (state == DONE);
    end

    // Converter datapath; digit registers change only in DONE, so a reset never leaves a partial write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_sec  <= '0;
            last_min  <= '0;
            sr_sec    <= '0;
            sr_min    <= '0;
            shift_cnt <= '0;
            sec_units <= '0;
            sec_tens  <= '0;
            min_units <= '0;
            min_tens  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        last_sec  <= seconds_in;
                        last_min  <= minutes_in;
                        sr_sec    <= {8'd0, seconds_in};
                        sr_min    <= {8'd0, minutes_in};
                        shift_cnt <= '0;
                    end
                end
                SHIFT: begin
                    sr_sec    <= dd_step(sr_sec);
                    sr_min    <= dd_step(sr_min);
                    shift_cnt <= shift_cnt + 3'd1;
                end
                DONE: begin
                    sec_units <= sr_sec[9:6];
                    sec_tens  <= sr_sec[13:10];
                    min_units <= sr_min[9:6];
                    min_tens  <= sr_min[13:10];
                end
                default: ;
            endcase
        end
    end

    assign idx_next = (pre == PRE_LAST) ? idx + 2'd1 : idx;

    always_comb begin
        case (idx_next)
            2'd0:    cur_digit = sec_units;
            2'd1:    cur_digit = sec_tens;
            2'd2:    cur_digit = min_units;
            default: cur_digit = min_tens;
        endcase
        seg_on = seg_encode(cur_digit);
`ifdef LEAD_ZERO_BLANK_EN
        if (idx_next == 2'd3 && min_tens == 4'd0) seg_on = 7'h00;
`endif
    end

    // Segments and dp are registered from the upcoming index so they switch together with digit_en.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre      <= '0;
            idx      <= '0;
            digit_en <= 4'b0001;
            seg_out  <= SEG_ACTIVE_LOW ? 7'h40 : 7'h3F;
            dp_out   <= SEG_ACTIVE_LOW;
        end else begin
            pre      <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
            idx      <= idx_next;
            digit_en <= 4'b0001 << idx_next;
            seg_out  <= SEG_ACTIVE_LOW ? ~seg_on : seg_on;
            dp_out   <= (idx_next == 2'd2) ^ SEG_ACTIVE_LOW;
        end
    end

endmodule

// File: tb/tb_clock_display_scan.sv
// Randomized and directed bench for clock_display_scan against a cycle-level arithmetic model.
module tb_clock_display_scan;

    localparam int SCAN_DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] seconds_in;
    logic [5:0] minutes_in;
    logic [3:0] digit_en;
    logic [6:0] seg_out;
    logic       dp_out;
    logic       conv_busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    clock_display_scan #(.SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .seconds_in (seconds_in),
        .minutes_in (minutes_in),
        .digit_en   (digit_en),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .conv_busy  (conv_busy)
    );

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference model: displayed values, pending capture, remaining busy cycles, scan position.
    int m_last_sec, m_last_min, m_cap_sec, m_cap_min;
    int m_disp_sec, m_disp_min, m_busy_left, m_pre, m_idx;
    logic [3:0] m_en;
    logic [6:0] m_seg;
    logic       m_dp;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int idx, input int sec, input int mn);
        int d;
        logic [6:0] on;
        case (idx)
            0:       d = sec % 10;
            1:       d = sec / 10;
            2:       d = mn % 10;
            default: d = mn / 10;
        endcase
        on = (d <= 9) ? seg_tab[d] : 7'h00;
`ifdef LEAD_ZERO_BLANK_EN
        if (idx == 3 && mn / 10 == 0) on = 7'h00;
`endif
        return ~on;
    endfunction

    task automatic model_reset();
        m_last_sec = 0; m_last_min = 0; m_cap_sec = 0; m_cap_min = 0;
        m_disp_sec = 0; m_disp_min = 0; m_busy_left = 0; m_pre = 0; m_idx = 0;
        m_en = 4'b0001; m_seg = ~7'h3F; m_dp = 1'b1;
    endtask

    task automatic model_edge();
        if (m_pre == SCAN_DIV - 1) begin
            m_pre = 0;
            m_idx = (m_idx + 1) % 4;
        end else begin
            m_pre++;
        end
        m_seg = exp_seg(m_idx, m_disp_sec, m_disp_min);
        m_dp  = (m_idx != 2);
        m_en  = 4'(1 << m_idx);
        if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) begin
                m_disp_sec = m_cap_sec;
                m_disp_min = m_cap_min;
            end
        end else if (int'(seconds_in) != m_last_sec || int'(minutes_in) != m_last_min) begin
            m_last_sec = seconds_in; m_last_min = minutes_in;
            m_cap_sec  = seconds_in; m_cap_min  = minutes_in;
            m_busy_left = 7;
        end
    endtask

    task automatic check_all();
        check_eq("digit_en", digit_en, m_en);
        check_eq("seg_out", seg_out, m_seg);
        check_eq("dp_out", dp_out, m_dp);
        check_eq("conv_busy", conv_busy, m_busy_left > 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int busy_cnt;
        bit found;
        reset = 1'b0;
        seconds_in = 6'd0;
        minutes_in = 6'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        reset = 1'b1;
        run(10);

        // Conversion of 12:37 and its busy window length
        seconds_in = 6'd37; minutes_in = 6'd12;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (conv_busy) busy_cnt++;
        end
        check_eq("busy_len", 16'(busy_cnt), 16'd7);
        run(20);

        // Input change in the middle of a conversion
        seconds_in = 6'd10;
        run(3);
        seconds_in = 6'd11;
        run(30);

        // Out-of-range minutes and a seconds rollover
        seconds_in = 6'd59; minutes_in = 6'd30;
        run(12);
        seconds_in = 6'd0; minutes_in = 6'd63;
        run(40);

        // Asynchronous reset while converting with index 2 active
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            if (m_idx == 2 && m_pre == 0 && m_busy_left == 0) found = 1'b1;
            else step();
        end
        check_eq("idx2_found", 16'(found), 16'd1);
        seconds_in = 6'd45; minutes_in = 6'd27;
        run(3);
        #2 reset = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        check_all();
        reset = 1'b1;
        run(30);

        // Leading-zero minutes
        minutes_in = 6'd5;
        run(30);
        minutes_in = 6'd15;
        run(30);

        // Random values held for random durations
        for (int k = 0; k < 200; k++) begin
            seconds_in = 6'($urandom_range(0, 63));
            minutes_in = 6'($urandom_range(0, 63));
            run($urandom_range(1, 12));
        end
        run(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clock_display_scan.md
Name: clock_display_scan

Overview:
- Downstream consumer of the seconds/minutes counter outputs in the real-time clock top level.
- Converts the 6-bit binary seconds and minutes values to BCD with a sequential double-dabble engine.
- Drives a 4-digit multiplexed 7-segment display (MM.SS) with a programmable scan rate.
- Instantiated beside the seconds and minutes counters; its inputs connect directly to their q outputs.

Parameters:
- SCAN_DIV, 50000: clk cycles each digit stays active; legal range ≥ 2.
- SEG_ACTIVE_LOW, 1: when 1, seg_out and dp_out are inverted (common-anode); when 0, active-high.

Ports:
- clk  input  1  system clock; all flops rising-edge.
- reset  input  1  asynchronous, active-low reset. One clock; asynchronous active-low reset is fixed.
- seconds_in  input  6  binary seconds from the seconds counter.
- minutes_in  input  6  binary minutes from the minutes counter.
- digit_en  output  4  one-hot digit select, active-high. bit0 = seconds units, bit1 = seconds tens, bit2 = minutes units, bit3 = minutes tens.
- seg_out  output  7  segments; bit0 = a … bit6 = g; polarity set by SEG_ACTIVE_LOW.
- dp_out  output  1  decimal point, used as the MM.SS separator.
- conv_busy  output  1  high while a conversion is in flight.

Behaviour:
- Reset (reset = 0, asynchronous):
  - Converter FSM goes to IDLE.
  - last_sec, last_min, all four digit registers, prescaler and digit index go to 0.
  - digit_en = 4'b0001, conv_busy = 0.
  - seg_out shows "0" (7'h3F, inverted when SEG_ACTIVE_LOW = 1: 7'h40).
  - dp_out inactive.
- Converter FSM, states IDLE → SHIFT → DONE → IDLE:
  - IDLE: on an edge where {minutes_in, seconds_in} != {last_min, last_sec}:
    - capture both inputs into last_min, last_sec and into two 14-bit double-dabble shift registers;
    - clear the shift counter; go to SHIFT.
  - SHIFT: exactly 6 cycles, counter 0..5. Each cycle, for each value:
    - add 3 to any BCD nibble ≥ 5,
    - then shift left by 1.
    - Both values are converted in parallel.
  - DONE: one cycle. Write sec_units, sec_tens, min_units, min_tens into the digit registers, then return to IDLE.
  - Latency: digit registers update on the 7th edge after the capture edge.
  - conv_busy is high in SHIFT and DONE: 7 cycles per conversion.
- Boundary conditions:
  - Inputs that change during SHIFT or DONE are ignored. They are compared again in IDLE, so the final stable value is always displayed. Back-to-back conversions are allowed with no idle gap beyond 1 cycle.
  - Values 60..63 are converted and shown unmodified (e.g. 63 → "63"). No saturation.
  - Tens digit is never > 6; units digit is never > 9. Any BCD code > 9 decodes to all segments off.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 continuously and is independent of the converter.
  - At the terminal count, the prescaler wraps to 0 and the digit index advances 0→1→2→3→0.
  - digit_en = 1 << index.
  - seg_out and dp_out are registered, updated on the same edge as digit_en, so no ghosting skew.
  - dp_out is active only when index = 2 (dot after minutes units).
- Segment codes (active-high): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Reset mid-conversion or mid-scan: immediate return to reset values. No partial digit writes.

Optional Feature:
- LEAD_ZERO_BLANK_EN defined:
  - when min_tens = 0, the index-3 slot drives seg_out all-off (polarity-adjusted);
  - digit_en still scans bit3, so scan timing is unchanged.
- Not defined: min_tens is always displayed, including "0".

Test Plan:
1. Reset low with inputs 0, then release → digit_en = 0001, seg_out = 7'h40 (SEG_ACTIVE_LOW = 1), conv_busy = 0, no conversion starts.
2. SCAN_DIV = 4, seconds_in = 37, minutes_in = 12 → conv_busy high for 7 cycles; digit registers become 7, 3, 2, 1. Scan sequence shows seg ~07, ~4F, ~5B, ~06; digit_en changes every 4 cycles; dp active only on the 0100 slot.
3. seconds_in 10 → 11 during the 3rd SHIFT cycle → first conversion completes showing 10, second conversion starts 1 cycle later, final display 11.
4. seconds 59 → 0 together with minutes_in = 63 → display "63.00"; no out-of-range codes appear.
5. Assert reset during SHIFT while index = 2 → outputs return to reset values asynchronously. After release, a conversion of the held inputs begins on the first edge.
6. LEAD_ZERO_BLANK_EN, minutes_in = 5 → index-3 slot shows segments off; minutes_in = 15 → shows "1".
